// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller and MEM/WB pipeline register: turns EX/MEM load/store
// requests into a dcache request/dhit handshake and stalls upstream until done.
module mem_stage_ctrl #(
   parameter int WORD_W  = 32,
   parameter int REG_W   = 5,
   parameter int TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              valid_EX_MEM,
   input  logic              dmemREN_EX_MEM,
   input  logic              dmemWEN_EX_MEM,
   input  logic [WORD_W-1:0] dmemaddr_EX_MEM,
   input  logic [WORD_W-1:0] dmemstore_EX_MEM,
   input  logic [WORD_W-1:0] result_EX_MEM,
   input  logic              WEN_EX_MEM,
   input  logic [REG_W-1:0]  wsel_EX_MEM,
   input  logic              mem_to_reg_EX_MEM,
   input  logic              halt_EX_MEM,
   input  logic              flush_MEM_WB,
   input  logic              dhit,
   input  logic [WORD_W-1:0] dmemload,
   output logic              dREN,
   output logic              dWEN,
   output logic [WORD_W-1:0] daddr,
   output logic [WORD_W-1:0] dstore,
   output logic              mem_stall,
   output logic              WEN_MEM_WB,
   output logic [REG_W-1:0]  wsel_MEM_WB,
   output logic [WORD_W-1:0] wdat_MEM_WB,
   output logic              halt_MEM_WB,
   output logic              mem_err,
   output logic [1:0]        dbg_state
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic              TO_EN    = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             w_memop;
   logic             w_active;
   logic             w_capture;

   assign daddr     = dmemaddr_EX_MEM;
   assign dstore    = dmemstore_EX_MEM;
   assign dbg_state = r_state;

   // Handshake: a request is held on dREN/dWEN until the cycle dhit is seen;
   // dhit only counts while a request is presented, and nothing is requested once halted.
   always_comb begin
      w_memop   = valid_EX_MEM & (dmemREN_EX_MEM | dmemWEN_EX_MEM);
      w_active  = (r_state != HALTED);
      dREN      = w_active & w_memop & dmemREN_EX_MEM;
      dWEN      = w_active & w_memop & dmemWEN_EX_MEM;
      mem_stall = w_active & w_memop & ~dhit;
      w_capture = w_active & ~mem_stall & ~flush_MEM_WB;
      w_next    = r_state;
      case (r_state)
         IDLE: begin
            if (w_capture & valid_EX_MEM & halt_EX_MEM) w_next = HALTED;
            else if (w_memop & ~dhit)                 w_next = WAIT;
         end
         WAIT: begin
            if (w_capture & valid_EX_MEM & halt_EX_MEM) w_next = HALTED;
            else if (~mem_stall)                       w_next = IDLE;
         end
         HALTED:  w_next = HALTED;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Counter restarts every time WAIT is entered; mem_err latches the edge it reaches TIMEOUT.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt   <= '0;
         mem_err <= 1'b0;
      end else begin
         if (r_state != WAIT)                  r_cnt <= '0;
         else if (mem_stall && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
         if (TO_EN && r_state == WAIT && mem_stall && r_cnt == CNT_LAST)
            mem_err <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         WEN_MEM_WB  <= 1'b0;
         wsel_MEM_WB <= '0;
         wdat_MEM_WB <= '0;
         halt_MEM_WB <= 1'b0;
      end else if (flush_MEM_WB) begin
         WEN_MEM_WB  <= 1'b0;
         wsel_MEM_WB <= '0;
         wdat_MEM_WB <= '0;
      end else if (w_capture) begin
         WEN_MEM_WB  <= valid_EX_MEM & WEN_EX_MEM;
         wsel_MEM_WB <= wsel_EX_MEM;
         wdat_MEM_WB <= mem_to_reg_EX_MEM ? dmemload : result_EX_MEM;
         halt_MEM_WB <= valid_EX_MEM & halt_EX_MEM;
      end else begin
         WEN_MEM_WB  <= 1'b0;
      end
   end

endmodule
